// File: rtl/shooter_pkg.sv
// Shared game-state encoding and explosion timing for the shooter core.
package shooter_pkg;

    typedef enum logic [1:0] {
        COUNTDOWN = 2'd0,
        PLAY      = 2'd1,
        WIN       = 2'd2
    } game_state_e;

    localparam logic [1:0] EXPL_LAST_FRAME = 2'd2;

endpackage

// File: rtl/game_tick_gen.sv
// Game tick divider: one-cycle registered pulse every TICK_DIV clocks.
module game_tick_gen #(
    parameter int TICK_DIV = 10000000
) (
    input  logic CLK_50,
    input  logic reset,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic          tick_q;

    always_ff @(posedge CLK_50) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else if (cnt_q == CW'(TICK_DIV - 1)) begin
            cnt_q  <= '0;
            tick_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_q + 1'b1;
            tick_q <= 1'b0;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/shooter_game_core.sv
// Shooter game core: countdown, play field with bullet slots, win screen.
// Define SHOOTER_SCORE_EN to build the saturating hit counter.
module shooter_game_core
    import shooter_pkg::*;
#(
    parameter int ENEMY_COUNT = 6,
    parameter int ROWS        = 6,
    parameter int NUM_BULLETS = 2,
    parameter int TICK_DIV    = 10000000,
    parameter int DELAY_TICKS = 3,
    localparam int LW = $clog2(2 * ENEMY_COUNT),
    localparam int RW = $clog2(ROWS + 1)
) (
    input  logic                      CLK_50,
    input  logic                      reset,
    input  logic                      btn_left,
    input  logic                      btn_right,
    input  logic                      btn_fire,
    output logic                      tick,
    output logic [1:0]                state,
    output logic [LW-1:0]             player_pos,
    output logic                      enemy_phase,
    output logic [ENEMY_COUNT-1:0]    enemy_alive,
    output logic [NUM_BULLETS-1:0]    bullet_valid,
    output logic [NUM_BULLETS*LW-1:0] bullet_x,
    output logic [NUM_BULLETS*RW-1:0] bullet_y,
    output logic                      expl_valid,
    output logic [LW-1:0]             expl_pos,
    output logic [1:0]                expl_frame,
    output logic                      win_blink,
    output logic [7:0]                score
);

    localparam int CNTW = (DELAY_TICKS > 1) ? $clog2(DELAY_TICKS) : 1;

    logic tick_w;

    game_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .CLK_50(CLK_50),
        .reset (reset),
        .tick  (tick_w)
    );

    // {fire, right, left}
    logic [2:0] sync1_q, sync2_q;

    game_state_e                      state_q, state_d;
    logic [CNTW-1:0]                  cnt_q, cnt_d;
    logic [LW-1:0]                    pos_q, pos_d;
    logic                             phase_q, phase_d;
    logic [ENEMY_COUNT-1:0]           alive_q, alive_d;
    logic [NUM_BULLETS-1:0]           bv_q, bv_d;
    logic [NUM_BULLETS-1:0][LW-1:0]   bx_q, bx_d;
    logic [NUM_BULLETS-1:0][RW-1:0]   by_q, by_d;
    logic                             ev_q, ev_d;
    logic [LW-1:0]                    ep_q, ep_d;
    logic [1:0]                       ef_q, ef_d;
    logic                             blink_q, blink_d;
    logic                             hit, fired;
    logic [LW-1:0]                    hit_lane;
`ifdef SHOOTER_SCORE_EN
    logic [7:0]                       score_q, score_d;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pos_d    = pos_q;
        phase_d  = phase_q;
        alive_d  = alive_q;
        bv_d     = bv_q;
        bx_d     = bx_q;
        by_d     = by_q;
        ev_d     = ev_q;
        ep_d     = ep_q;
        ef_d     = ef_q;
        blink_d  = blink_q;
        hit      = 1'b0;
        hit_lane = '0;
        fired    = 1'b0;
`ifdef SHOOTER_SCORE_EN
        score_d  = score_q;
`endif
        if (tick_w) begin
            unique case (state_q)
                COUNTDOWN: begin
                    if (cnt_q == '0) state_d = PLAY;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                PLAY: begin
                    phase_d = ~phase_q;
                    // A cleared enemy bit makes later slots on that enemy retire silently
                    for (int k = 0; k < NUM_BULLETS; k++) begin
                        if (bv_q[k] && by_q[k] == RW'(1)) begin
                            bv_d[k] = 1'b0;
                            if (bx_q[k][0] == phase_q &&
                                alive_d[bx_q[k][LW-1:1]]) begin
                                alive_d[bx_q[k][LW-1:1]] = 1'b0;
                                if (!hit) begin
                                    hit      = 1'b1;
                                    hit_lane = bx_q[k];
                                end
`ifdef SHOOTER_SCORE_EN
                                if (score_d != 8'hFF) score_d = score_d + 8'd1;
`endif
                            end
                        end else if (bv_q[k]) begin
                            by_d[k] = by_q[k] - 1'b1;
                        end
                    end
                    for (int k = 0; k < NUM_BULLETS; k++) begin
                        if (sync2_q[2] && !fired && !bv_d[k]) begin
                            bv_d[k] = 1'b1;
                            bx_d[k] = pos_q;
                            by_d[k] = RW'(ROWS);
                            fired   = 1'b1;
                        end
                    end
                    if (sync2_q[1]) begin
                        if (pos_q != LW'(2 * ENEMY_COUNT - 1)) pos_d = pos_q + 1'b1;
                    end else if (sync2_q[0] && pos_q != '0) begin
                        pos_d = pos_q - 1'b1;
                    end
                    if (alive_d == '0) begin
                        state_d = WIN;
                        bv_d    = '0;
                        bx_d    = '0;
                        by_d    = '0;
                    end
                end
                WIN:     blink_d = ~blink_q;
                default: state_d = COUNTDOWN;
            endcase
            if (hit) begin
                ev_d = 1'b1;
                ep_d = hit_lane;
                ef_d = 2'd0;
            end else if (ev_q) begin
                if (ef_q == EXPL_LAST_FRAME) ev_d = 1'b0;
                else                         ef_d = ef_q + 2'd1;
            end
        end
    end

    always_ff @(posedge CLK_50) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            state_q <= COUNTDOWN;
            cnt_q   <= CNTW'(DELAY_TICKS - 1);
            pos_q   <= LW'(ENEMY_COUNT / 2);
            phase_q <= 1'b0;
            alive_q <= '1;
            bv_q    <= '0;
            bx_q    <= '0;
            by_q    <= '0;
            ev_q    <= 1'b0;
            ep_q    <= '0;
            ef_q    <= '0;
            blink_q <= 1'b0;
        end else begin
            sync1_q <= {btn_fire, btn_right, btn_left};
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            phase_q <= phase_d;
            alive_q <= alive_d;
            bv_q    <= bv_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            ev_q    <= ev_d;
            ep_q    <= ep_d;
            ef_q    <= ef_d;
            blink_q <= blink_d;
        end
    end

`ifdef SHOOTER_SCORE_EN
    always_ff @(posedge CLK_50) begin
        if (reset) score_q <= '0;
        else       score_q <= score_d;
    end
    assign score = score_q;
`else
    assign score = 8'd0;
`endif

    assign tick         = tick_w;
    assign state        = state_q;
    assign player_pos   = pos_q;
    assign enemy_phase  = phase_q;
    assign enemy_alive  = alive_q;
    assign bullet_valid = bv_q;
    assign bullet_x     = bx_q;
    assign bullet_y     = by_q;
    assign expl_valid   = ev_q;
    assign expl_pos     = ep_q;
    assign expl_frame   = ef_q;
    assign win_blink    = blink_q;

endmodule

// File: tb/tb_shooter_game_core.sv
// Scoreboard bench for shooter_game_core: tick-tagged expectations in a queue.
module tb_shooter_game_core;

    logic       CLK_50, reset;
    logic       btn_left, btn_right, btn_fire;
    logic       tick;
    logic [1:0] state;
    logic [3:0] player_pos;
    logic       enemy_phase;
    logic [5:0] enemy_alive;
    logic [1:0] bullet_valid;
    logic [7:0] bullet_x;
    logic [5:0] bullet_y;
    logic       expl_valid;
    logic [3:0] expl_pos;
    logic [1:0] expl_frame;
    logic       win_blink;
    logic [7:0] score;

    shooter_game_core #(
        .ENEMY_COUNT(6), .ROWS(6), .NUM_BULLETS(2),
        .TICK_DIV(4), .DELAY_TICKS(3)
    ) dut (
        .CLK_50(CLK_50), .reset(reset),
        .btn_left(btn_left), .btn_right(btn_right), .btn_fire(btn_fire),
        .tick(tick), .state(state), .player_pos(player_pos),
        .enemy_phase(enemy_phase), .enemy_alive(enemy_alive),
        .bullet_valid(bullet_valid), .bullet_x(bullet_x), .bullet_y(bullet_y),
        .expl_valid(expl_valid), .expl_pos(expl_pos), .expl_frame(expl_frame),
        .win_blink(win_blink), .score(score)
    );

    initial CLK_50 = 1'b0;
    always #5 CLK_50 = ~CLK_50;

    typedef enum int {
        F_STATE, F_POS, F_PHASE, F_ALIVE, F_BV, F_BX0, F_BX1,
        F_BY0, F_BY1, F_EV, F_EP, F_EF, F_BLINK, F_SCORE
    } field_e;

    typedef struct {
        int         tag;
        field_e     f;
        logic [7:0] v;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 0;

    function automatic logic [7:0] sc(int n);
`ifdef SHOOTER_SCORE_EN
        return 8'(n);
`else
        return 8'd0 & 8'(n);
`endif
    endfunction

    function automatic string fname(field_e f);
        case (f)
            F_STATE: return "state";
            F_POS:   return "player_pos";
            F_PHASE: return "enemy_phase";
            F_ALIVE: return "enemy_alive";
            F_BV:    return "bullet_valid";
            F_BX0:   return "bullet_x0";
            F_BX1:   return "bullet_x1";
            F_BY0:   return "bullet_y0";
            F_BY1:   return "bullet_y1";
            F_EV:    return "expl_valid";
            F_EP:    return "expl_pos";
            F_EF:    return "expl_frame";
            F_BLINK: return "win_blink";
            default: return "score";
        endcase
    endfunction

    function automatic logic [7:0] dutv(field_e f);
        case (f)
            F_STATE: return {6'd0, state};
            F_POS:   return {4'd0, player_pos};
            F_PHASE: return {7'd0, enemy_phase};
            F_ALIVE: return {2'd0, enemy_alive};
            F_BV:    return {6'd0, bullet_valid};
            F_BX0:   return {4'd0, bullet_x[3:0]};
            F_BX1:   return {4'd0, bullet_x[7:4]};
            F_BY0:   return {5'd0, bullet_y[2:0]};
            F_BY1:   return {5'd0, bullet_y[5:3]};
            F_EV:    return {7'd0, expl_valid};
            F_EP:    return {4'd0, expl_pos};
            F_EF:    return {6'd0, expl_frame};
            F_BLINK: return {7'd0, win_blink};
            default: return score;
        endcase
    endfunction

    task automatic chk(string name, int tg, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @tick %0d: got 0x%0h expected 0x%0h", name, tg, act, exp);
        end
    endtask

    task automatic e(int tg, field_e f, logic [7:0] v);
        exp_t x;
        x.tag = tg;
        x.f   = f;
        x.v   = v;
        q.push_back(x);
    endtask

    // Buttons {fire, right, left} held during tick t
    function automatic logic [2:0] btns(int t);
        if (t == 4)              return 3'b001;
        if (t == 6)              return 3'b100;
        if (t >= 16 && t <= 25)  return 3'b010;
        if (t == 26 || t == 27)  return 3'b001;
        if (t == 28)             return 3'b011;
        if (t >= 29 && t <= 32)  return 3'b110;
        if (t == 37 || t == 39 || t == 43 || t == 45) return 3'b101;
        if (t == 38 || t == 40 || t == 44)            return 3'b001;
        if (t >= 46 && t <= 48)  return 3'b001;
        if (t == 49)             return 3'b100;
        if (t == 56 || t == 57)  return 3'b010;
        return 3'b000;
    endfunction

    task automatic load_expect();
        e(1, F_STATE, 0);
        e(2, F_STATE, 0);
        e(3, F_STATE, 1); e(3, F_POS, 3); e(3, F_ALIVE, 8'h3F); e(3, F_PHASE, 0);
        e(4, F_POS, 2); e(4, F_PHASE, 1);
        e(6, F_BV, 1); e(6, F_BY0, 6); e(6, F_BX0, 2);
        e(7, F_BY0, 5);
        e(8, F_BY0, 4);
        e(9, F_BY0, 3);
        e(10, F_BY0, 2);
        e(11, F_BY0, 1); e(11, F_BV, 1);
        e(12, F_BV, 0); e(12, F_ALIVE, 8'h3D); e(12, F_EV, 1); e(12, F_EP, 2);
        e(12, F_EF, 0); e(12, F_SCORE, sc(1)); e(12, F_PHASE, 1);
        e(13, F_EF, 1); e(13, F_EV, 1);
        e(14, F_EF, 2); e(14, F_EV, 1);
        e(15, F_EV, 0);
        e(20, F_POS, 7);
        e(24, F_POS, 11);
        e(25, F_POS, 11);
        e(26, F_POS, 10);
        e(27, F_POS, 9);
        e(28, F_POS, 10);
        e(29, F_BV, 1); e(29, F_BX0, 10); e(29, F_POS, 11);
        e(30, F_BV, 3); e(30, F_BX1, 11); e(30, F_BY1, 6); e(30, F_BY0, 5);
        e(31, F_BV, 3); e(31, F_BY0, 4); e(31, F_BY1, 5);
        e(32, F_BV, 3);
        e(35, F_BV, 2); e(35, F_ALIVE, 8'h3D); e(35, F_SCORE, sc(1)); e(35, F_BY1, 1);
        e(36, F_BV, 0); e(36, F_ALIVE, 8'h3D); e(36, F_SCORE, sc(1));
        e(37, F_BV, 1); e(37, F_BX0, 11); e(37, F_POS, 10);
        e(39, F_BV, 3); e(39, F_BX1, 9);
        e(43, F_ALIVE, 8'h1D); e(43, F_EV, 1); e(43, F_EP, 11); e(43, F_EF, 0);
        e(43, F_SCORE, sc(2)); e(43, F_BX0, 7); e(43, F_BV, 3);
        e(44, F_EF, 1);
        e(45, F_ALIVE, 8'h0D); e(45, F_EP, 9); e(45, F_EF, 0);
        e(45, F_SCORE, sc(3)); e(45, F_BX1, 5);
        e(49, F_ALIVE, 8'h05); e(49, F_SCORE, sc(4)); e(49, F_BX0, 1); e(49, F_POS, 1);
        e(51, F_ALIVE, 8'h01); e(51, F_EP, 5); e(51, F_EF, 0); e(51, F_BV, 1);
        e(54, F_EV, 0);
        e(55, F_STATE, 2); e(55, F_ALIVE, 0); e(55, F_BV, 0); e(55, F_EV, 1);
        e(55, F_EP, 1); e(55, F_EF, 0); e(55, F_SCORE, sc(6)); e(55, F_BLINK, 0);
        e(56, F_BLINK, 1); e(56, F_STATE, 2); e(56, F_EF, 1);
        e(57, F_BLINK, 0); e(57, F_POS, 1); e(57, F_EF, 2); e(57, F_EV, 1);
    endtask

    // Monitor: every completed tick, pop and compare expectations for it
    initial begin
        int  mt;
        bit  pend;
        exp_t x;
        mt   = 0;
        pend = 0;
        forever begin
            @(negedge CLK_50);
            if (pend) begin
                mt++;
                pend = 0;
                while (q.size() > 0 && q[0].tag <= mt) begin
                    x = q.pop_front();
                    chk(fname(x.f), x.tag, 32'(dutv(x.f)), 32'(x.v));
                end
            end
            if (mon_en && tick && !reset) pend = 1;
        end
    end

    task automatic step();
        int n;
        n = 0;
        do begin
            @(negedge CLK_50);
            n++;
        end while (!tick && n < 50);
        if (!tick) begin
            checks++;
            failures++;
            $display("FAIL tick_timeout: got no tick required one within 50 cycles");
        end
        @(negedge CLK_50);
    endtask

    task automatic chk_reset(int tg);
        chk("rst_state", tg, 32'(state), 0);
        chk("rst_pos", tg, 32'(player_pos), 3);
        chk("rst_phase", tg, 32'(enemy_phase), 0);
        chk("rst_alive", tg, 32'(enemy_alive), 32'h3F);
        chk("rst_bv", tg, 32'(bullet_valid), 0);
        chk("rst_bx", tg, 32'(bullet_x), 0);
        chk("rst_by", tg, 32'(bullet_y), 0);
        chk("rst_ev", tg, 32'(expl_valid), 0);
        chk("rst_ep", tg, 32'(expl_pos), 0);
        chk("rst_ef", tg, 32'(expl_frame), 0);
        chk("rst_blink", tg, 32'(win_blink), 0);
        chk("rst_score", tg, 32'(score), 0);
        chk("rst_tick", tg, 32'(tick), 0);
    endtask

    initial begin
        reset     = 1'b1;
        btn_left  = 1'b0;
        btn_right = 1'b0;
        btn_fire  = 1'b0;
        load_expect();
        repeat (3) @(negedge CLK_50);
        reset = 1'b0;
        chk_reset(0);
        mon_en = 1;
        for (int t = 1; t <= 57; t++) begin
            {btn_fire, btn_right, btn_left} = btns(t);
            step();
        end
        // Reset asserted mid-explosion while in WIN
        {btn_fire, btn_right, btn_left} = 3'b000;
        reset = 1'b1;
        @(negedge CLK_50);
        chk_reset(58);
        chk("queue_drained", 58, 32'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shooter_game_core.md
SHOOTER_GAME_CORE -- requirements
Module: shooter_game_core

Interface
REQ-001 SHALL have parameter ENEMY_COUNT, default 6: number of enemies; player lanes = 2*ENEMY_COUNT.
REQ-002 SHALL have parameter ROWS, default 6: bullet launch row; row 1 is the enemy row.
REQ-003 SHALL have parameter NUM_BULLETS, default 2: number of concurrent bullet slots.
REQ-004 SHALL have parameter TICK_DIV, default 10000000: CLK_50 cycles per game tick.
REQ-005 SHALL have parameter DELAY_TICKS, default 3: countdown length in ticks.
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 SHALL have these ports (LW = clog2(2*ENEMY_COUNT), RW = clog2(ROWS+1)):
  - CLK_50  in  1  system clock.
  - reset  in  1  synchronous, active-high.
  - btn_left, btn_right, btn_fire  in  1 each  active-high, asynchronous to CLK_50.
  - tick  out  1  one-cycle game-tick pulse.
  - state  out  2  game state.
  - player_pos  out  LW  player lane.
  - enemy_phase  out  1  lane parity currently occupied by enemies.
  - enemy_alive  out  ENEMY_COUNT  one bit per enemy.
  - bullet_valid  out  NUM_BULLETS  one bit per bullet slot.
  - bullet_x  out  NUM_BULLETS*LW  packed bullet lanes.
  - bullet_y  out  NUM_BULLETS*RW  packed bullet rows.
  - expl_valid  out  1  explosion active.
  - expl_pos  out  LW  explosion lane.
  - expl_frame  out  2  explosion animation frame.
  - win_blink  out  1  blink bit for the win screen.
  - score  out  8  hit count.

Function
REQ-008 SHALL pulse tick for one cycle every TICK_DIV cycles; the divider restarts from 0 on reset.
REQ-009 SHALL pass each button through a two-flop synchroniser; all game updates use synchronised levels, sampled only on tick cycles.
REQ-010 SHALL implement state machine COUNTDOWN(0) -> PLAY(1) -> WIN(2); there is no other transition except reset to COUNTDOWN.
REQ-011 In COUNTDOWN, SHALL decrement the countdown counter per tick and enter PLAY on the tick where it reads 0; no other state changes in COUNTDOWN.
REQ-012 In PLAY, on each tick, SHALL toggle enemy_phase; enemy i occupies lane 2i+enemy_phase.
REQ-013 Player movement: btn_right has priority and increments player_pos, saturating at 2*ENEMY_COUNT-1; otherwise btn_left decrements, saturating at 0.
REQ-014 Each valid bullet SHALL decrement bullet_y by 1 per tick.
REQ-015 A bullet with y==1 SHALL retire (valid=0) on that tick.
REQ-016 A retiring bullet hits when bullet_x[0] equals the pre-toggle enemy_phase and enemy_alive[bullet_x>>1]==1; a hit clears that enemy bit.
REQ-017 Fire: if btn_fire is high and a slot is free after retirements, SHALL spawn exactly one bullet in the lowest free slot at x = pre-move player_pos, y = ROWS; if no slot is free, fire is ignored.
REQ-018 Simultaneous hits on the same enemy in one tick SHALL count once: the lowest slot wins, and the remaining bullets retire silently.
REQ-019 On a hit, SHALL set expl_valid=1, expl_pos=bullet lane and expl_frame=0.
REQ-020 Explosion frames SHALL advance 0->1->2 per tick; after frame 2, expl_valid clears; a new hit restarts the animation at frame 0.
REQ-021 When enemy_alive becomes all-zero, SHALL enter WIN on the same tick edge.
REQ-022 In WIN, win_blink toggles per tick; player, bullets and enemies are frozen; bullets are cleared.
REQ-023 bullet_x and bullet_y are slot-packed: slot k occupies bits [k*LW +: LW] and [k*RW +: RW] respectively.

Reset
REQ-024 Reset SHALL set the following values, taking effect at the next edge, including mid-game or mid-explosion:
  - state=COUNTDOWN, countdown=DELAY_TICKS-1.
  - player_pos=ENEMY_COUNT/2.
  - enemy_phase=0, enemy_alive all ones.
  - bullet_valid, bullet_x and bullet_y all 0.
  - expl_valid=0, expl_pos=0, expl_frame=0.
  - win_blink=0, score=0, tick=0.

Configuration
REQ-025 With SHOOTER_SCORE_EN defined, score SHALL increment by 1 per counted hit, saturating at 255.
REQ-026 Without SHOOTER_SCORE_EN, score SHALL be constant 0 and no score register exists.

Structure
REQ-027 Package shooter_pkg SHALL hold the state enum (COUNTDOWN, PLAY, WIN) and the explosion last-frame constant (2).
REQ-028 The tick divider SHALL be sub-module game_tick_gen (parameter TICK_DIV; ports CLK_50, reset, tick).
REQ-029 All remaining logic SHALL live in shooter_game_core.

Verification (bench: TICK_DIV=4, DELAY_TICKS=3, ENEMY_COUNT=6, ROWS=6, NUM_BULLETS=2)
REQ-030 Reset released -> state=0 for 3 ticks, state=1 after the 3rd tick, player_pos=3, enemy_alive=6'b111111.
REQ-031 btn_right held 10 ticks -> player_pos reaches 11 and stays there; btn_left and btn_right both held -> player_pos increments.
REQ-032 Fire at lane 2 with enemy_phase=0 at impact -> bullet_y runs 6,5,4,3,2,1 across ticks; at the impact tick enemy_alive[1]=0, expl_pos=2 with frames 0,1,2, score=1.
REQ-033 Fire held continuously -> at most 2 bullets valid; a third fire request is ignored until a slot retires; a miss (parity mismatch) leaves enemy_alive unchanged and score unchanged.
REQ-034 Kill all 6 enemies -> state=2 on the last-hit tick, win_blink toggles each tick, score=6; assert reset -> full reset values on the next cycle.
REQ-035 Build without SHOOTER_SCORE_EN -> score=0 throughout the REQ-032 scenario.
